// File: rtl/serv_fetch_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// serv_fetch_unit
//
// Instruction-fetch stage in front of the bit-serial immediate decoder and
// the instruction decoder. The next PC arrives from the serial datapath, W bits
// per cycle, LSB first, and is assembled in a shift register. A "commit" is the
// last chunk, qualified by i_pc_done. It loads the assembled PC into the
// fetch-address register. One Wishbone-style read is run per fetch request. The
// returned word is presented to the decoders with a single-cycle o_wb_en strobe.
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_pc_en      i_pc carries a valid PC chunk this cycle
//   i_pc[W-1:0]  PC chunk, LSB first
//   i_pc_done    marks the last chunk (only meaningful with i_pc_en)
//   i_fetch_req  start a fetch from the committed PC (honoured in IDLE only)
//   o_ibus_adr   fetch address, bits [1:0] always zero
//   o_ibus_cyc   bus request, held until the ack
//   i_ibus_rdt   read data
//   i_ibus_ack   read complete (only meaningful while o_ibus_cyc is high)
//   o_wb_en      one-cycle strobe: a new instruction is on o_wb_rdt
//   o_wb_rdt     instruction bits [31:2], held until the next ack
//   o_misalign   the committed PC had bit 1 or bit 0 set
//   o_busy       a bus transaction is in flight
//
// W must be 1 or 4.
// ---------------------------------------------------------------------------
module serv_fetch_unit #(
    parameter int          W        = 1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_pc_en,
    input  logic [W-1:0]  i_pc,
    input  logic          i_pc_done,
    input  logic          i_fetch_req,
    output logic [31:0]   o_ibus_adr,
    output logic          o_ibus_cyc,
    input  logic [31:0]   i_ibus_rdt,
    input  logic          i_ibus_ack,
    output logic          o_wb_en,
    output logic [29:0]   o_wb_rdt,
    output logic          o_misalign,
    output logic          o_busy
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUS  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        cyc_next;

    logic [31:0] sr;
    logic [31:0] new_pc;
    logic        commit;
    logic        ack_hit;

    // Word address and alignment flag of the committed PC.
    logic [29:0] adr;
    logic        misalign;

    // A commit that arrives while the bus address must stay frozen.
    logic [29:0] pend_adr;
    logic        pend_mis;
    logic        pend_vld;

    // The low read-data bits and the chunk that falls off the end of the
    // shift register are never needed.
    logic        unused_bits;

    // The chunk on i_pc completes the PC in the same cycle it arrives, so the
    // committed value is taken from the shift input rather than from sr.
    assign new_pc      = {i_pc, sr[31:W]};
    assign commit      = i_pc_en & i_pc_done;
    assign ack_hit     = (state == ST_BUS) & i_ibus_ack;
    assign unused_bits = ^{i_ibus_rdt[1:0], sr[W-1:0]};

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_BOOT;
            o_ibus_cyc <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state      <= state_next;
            o_ibus_cyc <= cyc_next;
            o_busy     <= cyc_next;
        end
    end

    // BOOT always issues the first fetch. A request that arrives while a
    // transaction is still open, including on its ack edge, is dropped.
    always_comb begin
        state_next = state;
        cyc_next   = 1'b0;
        case (state)
            ST_BOOT: state_next = ST_BUS;
            ST_IDLE: if (i_fetch_req) state_next = ST_BUS;
            ST_BUS:  if (i_ibus_ack)  state_next = ST_IDLE;
            default: state_next = ST_BOOT;
        endcase
        cyc_next = (state_next == ST_BUS);
    end

    // -----------------------------------------------------------------------
    // PC assembly
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr <= 32'h0000_0000;
        end else if (i_pc_en) begin
            sr <= new_pc;
        end
    end

    // -----------------------------------------------------------------------
    // Fetch address commit
    // -----------------------------------------------------------------------
    // The address may only move while no transaction is open. A commit in
    // IDLE lands directly, so a request in the same cycle fetches from it.
    // Otherwise the commit is parked and lands on the first IDLE cycle.
    // A newer commit in that cycle takes precedence over the parked one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            adr      <= RESET_PC[31:2];
            misalign <= 1'b0;
            pend_adr <= 30'd0;
            pend_mis <= 1'b0;
            pend_vld <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (commit) begin
                adr      <= new_pc[31:2];
                misalign <= |new_pc[1:0];
            end else if (pend_vld) begin
                adr      <= pend_adr;
                misalign <= pend_mis;
            end
            pend_vld <= 1'b0;
        end else if (commit) begin
            pend_adr <= new_pc[31:2];
            pend_mis <= |new_pc[1:0];
            pend_vld <= 1'b1;
        end
    end

    assign o_ibus_adr = {adr, 2'b00};
    assign o_misalign = misalign;

    // -----------------------------------------------------------------------
    // Instruction capture
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_en  <= 1'b0;
            o_wb_rdt <= 30'd0;
        end else begin
            o_wb_en <= ack_hit;
            if (ack_hit) begin
                o_wb_rdt <= i_ibus_rdt[31:2];
            end
        end
    end

endmodule

// File: tb/tb_serv_fetch_unit.sv
`timescale 1ns/1ps
module tb_serv_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        b_rst_n;

    // Main instance, W=4
    logic        a_pc_en, a_pc_done, a_req, a_ack;
    logic [3:0]  a_pc;
    logic [31:0] a_rdt, a_adr;
    logic        a_cyc, a_wb_en, a_mis, a_busy;
    logic [29:0] a_wb_rdt;

    // Second instance, W=1
    logic        b_pc_en, b_pc_done, b_req, b_ack;
    logic [0:0]  b_pc;
    logic [31:0] b_rdt, b_adr;
    logic        b_cyc, b_wb_en, b_mis, b_busy;
    logic [29:0] b_wb_rdt;
    bit          b_done = 0;

    serv_fetch_unit #(.W(4), .RESET_PC(RST_PC)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pc_en(a_pc_en), .i_pc(a_pc),
        .i_pc_done(a_pc_done), .i_fetch_req(a_req), .o_ibus_adr(a_adr),
        .o_ibus_cyc(a_cyc), .i_ibus_rdt(a_rdt), .i_ibus_ack(a_ack),
        .o_wb_en(a_wb_en), .o_wb_rdt(a_wb_rdt), .o_misalign(a_mis), .o_busy(a_busy)
    );

    serv_fetch_unit #(.W(1), .RESET_PC(RST_PC)) u_dut1 (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_pc_en(b_pc_en), .i_pc(b_pc),
        .i_pc_done(b_pc_done), .i_fetch_req(b_req), .o_ibus_adr(b_adr),
        .o_ibus_cyc(b_cyc), .i_ibus_rdt(b_rdt), .i_ibus_ack(b_ack),
        .o_wb_en(b_wb_en), .o_wb_rdt(b_wb_rdt), .o_misalign(b_mis), .o_busy(b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct packed {
        logic [31:0] adr;
        logic        mis;
    } fetch_t;

    fetch_t      addr_q[$];
    logic [29:0] rdt_q[$];
    logic [31:0] m_pc;          // most recently committed PC
    bit          m_busy;        // a fetch is outstanding
    bit          m_boot;        // next edge issues the boot fetch
    int          s_cnt, s_wait;
    logic [31:0] s_data;
    int          dir_wait = -1;
    bit          dir_data_en = 0;
    logic [31:0] dir_data;
    bit          exp_cyc = 0;
    bit          exp_wb  = 0;
    logic [29:0] last_rdt = 30'd0;
    int          n_acks = 0;
    int          n_wb   = 0;

    // Drives one cycle of stimulus (after a falling edge) and advances the
    // model to what the next rising edge must produce.
    task automatic drive(input bit req, input bit pen, input logic [3:0] chunk,
                         input bit done, input logic [31:0] val);
        bit     acked;
        fetch_t f;
        acked = 0;
        a_ack = 1'b0;
        a_rdt = $urandom;
        if (m_busy) begin
            if (s_cnt == s_wait) begin
                a_ack = 1'b1;
                a_rdt = s_data;
                acked = 1;
            end
            s_cnt++;
        end
        a_req     = req;
        a_pc_en   = pen;
        a_pc      = chunk;
        a_pc_done = pen & done;
        if (pen && done) m_pc = val;
        exp_wb = acked;
        if (acked) begin
            rdt_q.push_back(s_data[31:2]);
            n_acks++;
            m_busy = 0;
        end else if (!m_busy && (req || m_boot)) begin
            m_busy = 1;
            m_boot = 0;
            f.adr  = m_pc & ~32'd3;
            f.mis  = |m_pc[1:0];
            addr_q.push_back(f);
            s_cnt  = 0;
            s_wait = (dir_wait >= 0) ? dir_wait : int'($urandom_range(0, 4));
            s_data = dir_data_en ? dir_data : $urandom;
            dir_wait    = -1;
            dir_data_en = 0;
        end
        exp_cyc = m_busy;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 4'h0, 0, 32'h0);
    endtask

    task automatic wait_free();
        for (int i = 0; i < 40 && m_busy; i++) drive(0, 0, 4'h0, 0, 32'h0);
        chk("wait_free", 32'(m_busy), 32'd0);
    endtask

    task automatic send_pc(input logic [31:0] val);
        for (int i = 0; i < 8; i++) drive(0, 1, val[4*i +: 4], (i == 7), val);
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit          pcyc;
        logic [31:0] padr;
        fetch_t      f;
        logic [29:0] e;
        pcyc = 0;
        padr = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pcyc = 0;
                continue;
            end
            chk("cyc", 32'(a_cyc), 32'(exp_cyc));
            chk("busy", 32'(a_busy), 32'(exp_cyc));
            chk("wb_en", 32'(a_wb_en), 32'(exp_wb));
            if (a_wb_en) begin
                n_wb++;
                if (rdt_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wb_rdt: strobe with 0x%08h, required no strobe", {2'b00, a_wb_rdt});
                end else begin
                    e = rdt_q.pop_front();
                    chk("wb_rdt", {2'b00, a_wb_rdt}, {2'b00, e});
                    last_rdt = e;
                end
            end else begin
                chk("wb_rdt_hold", {2'b00, a_wb_rdt}, {2'b00, last_rdt});
            end
            if (a_cyc && !pcyc) begin
                if (addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fetch_adr: fetch started at 0x%08h, required no fetch", a_adr);
                end else begin
                    f = addr_q.pop_front();
                    chk("fetch_adr", a_adr, f.adr);
                    chk("fetch_mis", 32'(a_mis), 32'(f.mis));
                end
            end else if (a_cyc && pcyc) begin
                chk("adr_frozen", a_adr, padr);
            end else if (!a_cyc && !pcyc) begin
                chk("idle_adr", a_adr, m_pc & ~32'd3);
                chk("idle_mis", 32'(a_mis), 32'(|m_pc[1:0]));
            end
            pcyc = a_cyc;
            padr = a_adr;
        end
    end

    // ---------------- W=1 instance ----------------
    initial begin
        forever begin
            @(negedge clk);
            b_ack = b_cyc;
        end
    end

    initial begin
        logic [31:0] val;
        bit          found;
        val = 32'h0000_2004;
        found = 0;
        b_pc_en = 0; b_pc = 1'b0; b_pc_done = 0; b_req = 0; b_ack = 0;
        b_rdt = 32'hA5A5_5A5F;
        for (int i = 0; i < 100 && !b_rst_n; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            b_pc_en   = 1;
            b_pc      = val[i];
            b_pc_done = (i == 31);
            @(negedge clk);
        end
        b_pc_en = 0; b_pc_done = 0; b_req = 1;
        @(negedge clk);
        b_req = 0;
        chk("w1_cyc", 32'(b_cyc), 32'd1);
        chk("w1_busy", 32'(b_busy), 32'd1);
        chk("w1_adr", b_adr, 32'h0000_2004);
        chk("w1_mis", 32'(b_mis), 32'd0);
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #1;
            if (b_wb_en) found = 1;
        end
        chk("w1_wb_seen", 32'(found), 32'd1);
        chk("w1_wb_rdt", {2'b00, b_wb_rdt}, {2'b00, b_rdt[31:2]});
        b_done = 1;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] target;
        int          idx, nreq;
        bit          active, pen, done, req;
        logic [3:0]  chunk;

        rst_n = 0; b_rst_n = 0;
        a_pc_en = 0; a_pc = 4'h0; a_pc_done = 0; a_req = 0; a_ack = 0; a_rdt = 32'h0;
        m_pc = RST_PC; m_busy = 0; m_boot = 0;
        repeat (3) @(negedge clk);

        chk("rst_cyc", 32'(a_cyc), 32'd0);
        chk("rst_wb_en", 32'(a_wb_en), 32'd0);
        chk("rst_wb_rdt", {2'b00, a_wb_rdt}, 32'd0);
        chk("rst_mis", 32'(a_mis), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_adr", a_adr, RST_PC & ~32'd3);
        chk("rst_adr_w1", b_adr, RST_PC & ~32'd3);

        // Boot fetch with a two-wait-state slave
        dir_wait = 2; dir_data_en = 1; dir_data = 32'h0010_0093;
        rst_n = 1; b_rst_n = 1; m_boot = 1;
        idle(6);

        // Serial PC with a misaligned value
        send_pc(32'hDEAD_BEE6);
        drive(1, 0, 4'h0, 0, 32'h0);
        wait_free();
        idle(1);

        // Commit while the bus is waiting on a slow ack
        dir_wait = 12;
        drive(1, 0, 4'h0, 0, 32'h0);
        send_pc(32'h0000_3000);
        chk("deferred_hold", a_adr, 32'hDEAD_BEE4);
        wait_free();
        idle(1);
        chk("deferred_adr", a_adr, 32'h0000_3000);
        drive(1, 0, 4'h0, 0, 32'h0);
        wait_free();
        idle(1);

        // Commit on the ack edge lands one edge later
        dir_wait = 7;
        drive(1, 0, 4'h0, 0, 32'h0);
        send_pc(32'h0000_4008);
        chk("ack_commit_hold", a_adr, 32'h0000_3000);
        idle(1);
        chk("ack_commit_adr", a_adr, 32'h0000_4008);

        // Back-to-back requests with a zero-wait slave
        dir_wait = 0;
        drive(1, 0, 4'h0, 0, 32'h0);
        dir_wait = 0;
        drive(1, 0, 4'h0, 0, 32'h0);
        drive(1, 0, 4'h0, 0, 32'h0);
        wait_free();
        idle(2);

        // Random requests, commits and wait states
        nreq = 0; active = 0; idx = 0; target = 32'h0;
        for (int c = 0; c < 4000 && nreq < 100; c++) begin
            pen = 0; done = 0; chunk = 4'h0;
            if (!active && $urandom_range(0, 9) == 0) begin
                target = $urandom;
                idx = 0;
                active = 1;
            end
            if (active && $urandom_range(0, 1) == 1) begin
                pen = 1;
                chunk = target[4*idx +: 4];
                done = (idx == 7);
                idx++;
                if (done) active = 0;
            end
            req = ($urandom_range(0, 2) == 0);
            if (req) nreq++;
            drive(req, pen, chunk, done, target);
        end
        wait_free();
        idle(2);

        // Reset in the middle of a transaction, then a late ack
        dir_wait = 20;
        drive(1, 0, 4'h0, 0, 32'h0);
        idle(2);
        rst_n = 0;
        #1;
        chk("rst_mid_cyc", 32'(a_cyc), 32'd0);
        chk("rst_mid_busy", 32'(a_busy), 32'd0);
        m_busy = 0; m_pc = RST_PC; exp_cyc = 0; exp_wb = 0; last_rdt = 30'd0;
        addr_q.delete();
        rdt_q.delete();
        @(negedge clk);
        a_ack = 1; a_rdt = 32'hFFFF_FFFF;
        @(negedge clk);
        a_ack = 0;
        chk("rst_mid_no_wb", 32'(a_wb_en), 32'd0);
        @(negedge clk);
        dir_wait = 1;
        rst_n = 1; m_boot = 1;
        drive(0, 0, 4'h0, 0, 32'h0);
        wait_free();
        idle(1);
        drive(1, 0, 4'h0, 0, 32'h0);
        wait_free();
        idle(2);

        for (int i = 0; i < 2000 && !b_done; i++) @(negedge clk);
        chk("w1_done", 32'(b_done), 32'd1);
        chk("wb_count", 32'(n_wb), 32'(n_acks));
        chk("fetch_q_empty", 32'(addr_q.size()), 32'd0);
        chk("rdt_q_empty", 32'(rdt_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
